// File: rtl/hazard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_pkg : memory FSM state type and forwarding-select encodings  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } mem_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/dmem_wait_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_wait_fsm : data-memory handshake, pipeline freeze and timeout  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dmem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_access,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic memstall,
  output logic mem_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  mem_state_t      state;
  mem_state_t      state_nxt;
  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dmem_req  = 1'b0;
    memstall  = 1'b0;
    mem_err   = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = mem_access;
        if (mem_access && !dmem_ready) begin
          state_nxt = MEM_WAIT;
          cnt_nxt   = '0;
          memstall  = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (dmem_ready) begin
          state_nxt = IDLE;
        end else begin
          memstall = 1'b1;
          if (cnt == TO_LAST) state_nxt = MEM_ERR;
        end
      end
      MEM_ERR: begin
        memstall = 1'b1;
        mem_err  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // State is already forced to IDLE; this also masks a pending access.
    if (!reset_n) begin
      dmem_req = 1'b0;
      memstall = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_ctrl : forwarding, stall and flush control for 5-stage MIPS  |
// | Optional HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt.  Rev 1.0    |
// +--------------------------------------------------------------------+
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_e,
  input  logic [4:0] writereg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  input  logic       memtoreg_e,
  input  logic       memtoreg_m,
  input  logic       memwrite_m,
  input  logic       branch_d,
  input  logic       bne_d,
  input  logic       jump_d,
  input  logic       pcsrc_d,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic [1:0] forward_ae,
  output logic [1:0] forward_be,
  output logic       forward_ad,
  output logic       forward_bd,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic memstall;
  logic lwstall;
  logic brstall;

  dmem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_dmem_wait_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_access(memwrite_m | memtoreg_m),
    .dmem_ready(dmem_ready),
    .dmem_req  (dmem_req),
    .memstall  (memstall),
    .mem_err   (mem_err)
  );

  // M stage result is younger than W, so it wins when both match.
  always_comb begin
    forward_ae = FWD_RF;
    forward_be = FWD_RF;
    if (rs_e != 5'd0 && rs_e == writereg_m && regwrite_m)      forward_ae = FWD_M;
    else if (rs_e != 5'd0 && rs_e == writereg_w && regwrite_w) forward_ae = FWD_W;
    if (rt_e != 5'd0 && rt_e == writereg_m && regwrite_m)      forward_be = FWD_M;
    else if (rt_e != 5'd0 && rt_e == writereg_w && regwrite_w) forward_be = FWD_W;
  end

  assign forward_ad = (rs_d != 5'd0) && (rs_d == writereg_m) && regwrite_m;
  assign forward_bd = (rt_d != 5'd0) && (rt_d == writereg_m) && regwrite_m;

  assign lwstall = memtoreg_e && ((rs_d == rt_e) || (rt_d == rt_e));
  assign brstall = (branch_d | bne_d) &&
                   ((regwrite_e && ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                    (memtoreg_m && ((writereg_m == rs_d) || (writereg_m == rt_d))));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!reset_n) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (memstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (lwstall | brstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      flush_d = pcsrc_d | jump_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != 32'hFFFF_FFFF)               stall_cnt <= stall_cnt + 32'd1;
      if ((flush_d | flush_e) && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hazard_ctrl : directed + random bench against a reference model  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m, memwrite_m;
  logic       branch_d, bne_d, jump_d, pcsrc_d, dmem_ready;
  logic       dmem_req, forward_ad, forward_bd;
  logic [1:0] forward_ae, forward_be;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: outstanding access, cycles already waited, sticky error.
  bit         pend, err;
  int         waited;
  longint     scnt, fcnt;
  logic       e_req, e_err, e_mst;
  logic [3:0] e_stall;
  logic [1:0] e_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
    .branch_d(branch_d), .bne_d(bne_d), .jump_d(jump_d), .pcsrc_d(pcsrc_d),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd_e(input logic [4:0] src);
    if (src != 0 && regwrite_m && src == writereg_m) return 2'b10;
    if (src != 0 && regwrite_w && src == writereg_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_fwd_d(input logic [4:0] src);
    return src != 0 && regwrite_m && src == writereg_m;
  endfunction

  task automatic model_eval();
    bit acc, hz;
    if (!reset_n) begin
      pend = 0; err = 0; waited = 0; scnt = 0; fcnt = 0;
    end
    acc = memtoreg_m | memwrite_m;
    hz  = (memtoreg_e && (rs_d == rt_e || rt_d == rt_e)) ||
          ((branch_d | bne_d) &&
           ((regwrite_e && (writereg_e == rs_d || writereg_e == rt_d)) ||
            (memtoreg_m && (writereg_m == rs_d || writereg_m == rt_d))));
    e_err = err;
    e_req = reset_n && !err && (pend || acc);
    e_mst = reset_n && (err || ((pend || acc) && !dmem_ready));
    if (!reset_n)   begin e_stall = 4'b0000; e_flush = 2'b11; end
    else if (e_mst) begin e_stall = 4'b1111; e_flush = 2'b00; end
    else if (hz)    begin e_stall = 4'b1100; e_flush = 2'b01; end
    else            begin e_stall = 4'b0000; e_flush = {pcsrc_d | jump_d, 1'b0}; end
  endtask

  task automatic compare();
    model_eval();
    check("fwd", {forward_ae, forward_be, forward_ad, forward_bd},
          {ref_fwd_e(rs_e), ref_fwd_e(rt_e), ref_fwd_d(rs_d), ref_fwd_d(rt_d)});
    check("stall", {stall_f, stall_d, stall_e, stall_m}, e_stall);
    check("flush", {flush_d, flush_e}, e_flush);
    check("dmem_req", dmem_req, e_req);
    check("mem_err", mem_err, e_err);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", stall_cnt, scnt[31:0]);
    check("flush_cnt", flush_cnt, fcnt[31:0]);
`endif
  endtask

  task automatic check_now();
    @(negedge clk);
    compare();
  endtask

  task automatic adv();
    bit acc;
    @(posedge clk);
    model_eval();
    acc = memtoreg_m | memwrite_m;
    if (reset_n) begin
      if (e_stall[3] && scnt < 64'hFFFF_FFFF) scnt++;
      if ((|e_flush) && fcnt < 64'hFFFF_FFFF) fcnt++;
      if (!err && (pend || acc)) begin
        if (dmem_ready)                            pend = 0;
        else if (pend && waited == MEM_TIMEOUT-1) begin err = 1; pend = 0; end
        else if (pend)                             waited++;
        else begin pend = 1; waited = 0; end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    writereg_e = 0; writereg_m = 0; writereg_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    memtoreg_e = 0; memtoreg_m = 0; memwrite_m = 0;
    branch_d = 0; bne_d = 0; jump_d = 0; pcsrc_d = 0; dmem_ready = 0;
  endtask

  initial begin
    int req_cnt, st_cnt;
    clear_inputs();
    reset_n = 0;

    check_now();
    check("rst_flush", {flush_d, flush_e}, 2'b11);
    check("rst_stall", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
    adv();
    reset_n = 1;

    // Forwarding priority
    regwrite_m = 1; writereg_m = 8; regwrite_w = 1; writereg_w = 8; rs_e = 8;
    check_now(); check("fwd_m", forward_ae, 2'b10); adv();
    regwrite_m = 0;
    check_now(); check("fwd_w", forward_ae, 2'b01); adv();
    rs_e = 0;
    check_now(); check("fwd_r0", forward_ae, 2'b00); adv();

    // Load-use
    clear_inputs(); memtoreg_e = 1; rt_e = 9; rs_d = 9;
    check_now(); check("lw_stall", {stall_f, stall_d, flush_e, flush_d}, 4'b1110); adv();
    clear_inputs();
    check_now(); check("lw_done", {stall_f, flush_e}, 2'b00); adv();

    // Branch hazard then taken branch
    bne_d = 1; regwrite_e = 1; writereg_e = 4; rt_d = 4;
    check_now(); check("br_stall", {stall_f, flush_e}, 2'b11); adv();
    clear_inputs(); pcsrc_d = 1;
    check_now(); check("br_flush", {flush_d, flush_e}, 2'b10); adv();

    // Three wait states
    clear_inputs(); memtoreg_m = 1;
    req_cnt = 0; st_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      check_now();
      req_cnt += int'(dmem_req);
      st_cnt  += int'(stall_f & stall_d & stall_e & stall_m);
      adv();
    end
    check("wait_req_cycles", req_cnt, 4);
    check("wait_stall_cycles", st_cnt, 3);
    clear_inputs();
    check_now(); check("wait_idle", {dmem_req, stall_m}, 2'b00); adv();

    // Timeout
    memwrite_m = 1;
    for (int i = 0; i < 17; i++) begin
      check_now();
      if (i == 16) check("to_before", {mem_err, dmem_req}, 2'b01);
      adv();
    end
    check_now();
    check("to_err", {mem_err, dmem_req}, 2'b10);
    check("to_stall", {stall_f, stall_d, stall_e, stall_m}, 4'b1111);
    adv();
    memwrite_m = 0;
    check_now(); check("to_sticky", {mem_err, stall_f}, 2'b11); adv();
    reset_n = 0;
    check_now(); check("to_rst", mem_err, 1'b0); adv();
    reset_n = 1;
    check_now(); check("to_post", {mem_err, dmem_req, stall_f}, 3'b000); adv();

    // Asynchronous reset in the middle of a wait
    memtoreg_m = 1; dmem_ready = 0;
    check_now(); adv();
    check_now(); adv();
    #2 reset_n = 0;
    #1;
    compare();
    check("async_req", dmem_req, 1'b0);
    check("async_flush", {flush_d, flush_e}, 2'b11);
    adv();
    reset_n = 1; memtoreg_m = 0;
    check_now(); adv();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      writereg_e = 5'($urandom_range(0, 3));
      writereg_m = 5'($urandom_range(0, 3));
      writereg_w = 5'($urandom_range(0, 3));
      regwrite_e = 1'($urandom_range(0, 1));
      regwrite_m = 1'($urandom_range(0, 1));
      regwrite_w = 1'($urandom_range(0, 1));
      memtoreg_e = ($urandom_range(0, 3) == 0);
      memtoreg_m = ($urandom_range(0, 2) == 0);
      memwrite_m = ($urandom_range(0, 3) == 0);
      branch_d   = ($urandom_range(0, 3) == 0);
      bne_d      = ($urandom_range(0, 3) == 0);
      jump_d     = ($urandom_range(0, 4) == 0);
      pcsrc_d    = 1'($urandom_range(0, 1));
      dmem_ready = ($urandom_range(0, 2) == 0);
      reset_n    = !(($urandom_range(0, 99) == 0) || (err && $urandom_range(0, 3) == 0));
      check_now();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core (F/D/E/M/W); it sits beside the main decoder and datapath registers.
- Produces forwarding selects, stall and flush enables for every pipeline register.
- Runs a data-memory handshake FSM that freezes the pipeline while a load or store waits on a multi-cycle memory, with a timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before the error state.
TO_W, 5, timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
rs_d, rt_d  in  5  source registers in D
rs_e, rt_e  in  5  source registers in E
writereg_e, writereg_m, writereg_w  in  5  destination register per stage
regwrite_e, regwrite_m, regwrite_w  in  1  register-write flag per stage
memtoreg_e, memtoreg_m  in  1  load in E / M
memwrite_m  in  1  store in M
branch_d, bne_d, jump_d  in  1  control flow decoded in D
pcsrc_d  in  1  branch resolved taken in D
dmem_ready  in  1  memory completes the access this cycle
dmem_req  out  1  memory access request
forward_ae, forward_be  out  2  E operand select: 00 regfile, 01 W result, 10 M ALU result
forward_ad, forward_bd  out  1  D branch comparator takes the M ALU result
stall_f, stall_d, stall_e, stall_m  out  1  hold the corresponding pipeline register
flush_d, flush_e  out  1  clear the corresponding pipeline register to a bubble
mem_err  out  1  sticky memory-timeout error

Behaviour:
- Forwarding is combinational.
  - forward_ae = 10 when rs_e!=0, rs_e==writereg_m and regwrite_m.
  - Otherwise forward_ae = 01 when rs_e!=0, rs_e==writereg_w and regwrite_w.
  - Otherwise forward_ae = 00. M takes priority over W.
  - forward_be is the same rule using rt_e.
  - forward_ad = rs_d!=0 && rs_d==writereg_m && regwrite_m; forward_bd is the same using rt_d.
- Hazard terms:
  - lwstall = memtoreg_e && (rs_d==rt_e || rt_d==rt_e).
  - brstall = (branch_d|bne_d) && ((regwrite_e && writereg_e∈{rs_d,rt_d}) || (memtoreg_m && writereg_m∈{rs_d,rt_d})).
- Memory FSM states: IDLE, MEM_WAIT, MEM_ERR; mem_access = memwrite_m|memtoreg_m.
  - IDLE: dmem_req = mem_access.
    - mem_access && !dmem_ready -> MEM_WAIT, counter cleared to 0; memstall=1.
    - mem_access && dmem_ready -> stays IDLE; memstall=0 (zero-wait access).
  - MEM_WAIT: dmem_req=1, counter increments each cycle.
    - dmem_ready -> IDLE; memstall=0 in that same cycle.
    - Otherwise, counter==MEM_TIMEOUT-1 -> MEM_ERR; memstall=1.
  - MEM_ERR: dmem_req=0, memstall=1, mem_err=1. Exits only on reset.
  - dmem_ready outside a request is ignored.
- Stall/flush outputs:
  - memstall=1: stall_f=stall_d=stall_e=stall_m=1, flush_d=flush_e=0. Whole pipeline frozen; memstall dominates all other terms.
  - Otherwise, lwstall|brstall: stall_f=stall_d=1, flush_e=1, flush_d=0.
  - Otherwise: flush_d = pcsrc_d|jump_d.
- Reset (async, reset_n=0):
  - FSM to IDLE, counter 0, mem_err 0, dmem_req 0.
  - All stall outputs 0; flush_d=flush_e=1 while reset is held.
  - Reset mid-MEM_WAIT abandons the access; dmem_req drops immediately.
- Latency: forwarding and stall outputs are combinational, same cycle as their inputs. FSM state updates on the next clk edge.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] (cycles with stall_f=1) and flush_cnt[31:0] (cycles with flush_d|flush_e while reset_n=1). Both are saturating at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - enum mem_state_t {IDLE, MEM_WAIT, MEM_ERR};
  - forwarding select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module, dmem_wait_fsm, owns the FSM, the timeout counter, dmem_req, memstall and mem_err.
- Forwarding and stall logic stay in hazard_ctrl.

Test Plan:
- Forwarding: regwrite_m=1, writereg_m=8, regwrite_w=1, writereg_w=8, rs_e=8 -> forward_ae=10. Then regwrite_m=0 -> forward_ae=01. Then rs_e=0 -> 00.
- Load-use: memtoreg_e=1, rt_e=9, rs_d=9 -> stall_f=stall_d=1, flush_e=1, flush_d=0 for one cycle.
- Branch hazard: bne_d=1, regwrite_e=1, writereg_e=rt_d=4 -> stall_f=1, flush_e=1. Next cycle, with the hazard cleared and pcsrc_d=1 -> flush_d=1.
- Wait state: memtoreg_m=1, dmem_ready held 0 for 3 cycles then 1 -> dmem_req=1 for 4 cycles, all four stalls=1 for 3 cycles, FSM back to IDLE.
- Timeout: memwrite_m=1, dmem_ready=0 forever, MEM_TIMEOUT=16 -> mem_err rises after 16 MEM_WAIT cycles, dmem_req=0, stalls stay 1. reset_n pulse low -> mem_err=0, FSM IDLE.
- Async reset mid-wait: drop reset_n between clk edges in MEM_WAIT -> dmem_req=0 and flush_d=flush_e=1 immediately, without waiting for clk.
